// File: rtl/fifo_mc.sv
// fifo_mc: NUM_CH independent FIFOs sharing one push port, one pop port and one registered read-out.
// Ports: clk, reset (async, active-high); wr_en/wr_ch/data_in push; rd_en/rd_ch pop;
//   almost_empty_thr/almost_full_thr are live thresholds shared by every channel; err_clr clears sticky errors;
//   data_out/data_valid carry the popped word one cycle after the pop; count and *_flag give per-channel status.
module fifo_mc #(
  parameter int NUM_CH         = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_WORD_SIZE = 10,
  parameter int PTR_SIZE       = $clog2(FIFO_DEPTH),
  parameter int CH_SIZE        = $clog2(NUM_CH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [CH_SIZE-1:0]               wr_ch,
  input  logic [FIFO_WORD_SIZE-1:0]        data_in,
  input  logic                             rd_en,
  input  logic [CH_SIZE-1:0]               rd_ch,
  input  logic [PTR_SIZE:0]                almost_empty_thr,
  input  logic [PTR_SIZE:0]                almost_full_thr,
  input  logic                             err_clr,
  output logic [FIFO_WORD_SIZE-1:0]        data_out,
  output logic                             data_valid,
  output logic [NUM_CH*(PTR_SIZE+1)-1:0]   count,
  output logic [NUM_CH-1:0]                empty_flag,
  output logic [NUM_CH-1:0]                full_flag,
  output logic [NUM_CH-1:0]                almost_empty_flag,
  output logic [NUM_CH-1:0]                almost_full_flag,
  output logic [NUM_CH-1:0]                error_flag
);
  localparam logic [PTR_SIZE:0] DEPTH = (PTR_SIZE+1)'(FIFO_DEPTH);
  localparam logic [PTR_SIZE:0] ONE   = (PTR_SIZE+1)'(1);
  logic [PTR_SIZE:0] wr_ptr_q [NUM_CH];
  logic [PTR_SIZE:0] wr_ptr_d [NUM_CH];
  logic [PTR_SIZE:0] rd_ptr_q [NUM_CH];
  logic [PTR_SIZE:0] rd_ptr_d [NUM_CH];
  logic [PTR_SIZE:0] cnt [NUM_CH];
  logic [FIFO_WORD_SIZE-1:0] mem [NUM_CH*FIFO_DEPTH];
  logic [FIFO_WORD_SIZE-1:0] data_q, data_d;
  logic valid_q;
  logic [NUM_CH-1:0] err_q, err_d, err_set;
  logic rd_ok, wr_ok;
  // Status comes only from registered pointers; thresholds act without a register stage.
  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt[i] = wr_ptr_q[i] - rd_ptr_q[i];
      count[i*(PTR_SIZE+1) +: PTR_SIZE+1] = cnt[i];
      empty_flag[i] = cnt[i] == '0;
      full_flag[i] = cnt[i] == DEPTH;
      almost_empty_flag[i] = cnt[i] != '0 && cnt[i] <= almost_empty_thr;
      almost_full_flag[i] = cnt[i] >= almost_full_thr && cnt[i] != DEPTH;
    end
  end
  assign rd_ok = rd_en && !empty_flag[rd_ch];
  // A full channel can still take a push when the same edge pops from it.
  assign wr_ok = wr_en && (!full_flag[wr_ch] || (rd_ok && rd_ch == wr_ch));
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ptr_d[i] = wr_ok && wr_ch == CH_SIZE'(i) ? wr_ptr_q[i] + ONE : wr_ptr_q[i];
      rd_ptr_d[i] = rd_ok && rd_ch == CH_SIZE'(i) ? rd_ptr_q[i] + ONE : rd_ptr_q[i];
      err_set[i] = (wr_en && !wr_ok && wr_ch == CH_SIZE'(i)) || (rd_en && !rd_ok && rd_ch == CH_SIZE'(i));
    end
    data_d = rd_ok ? mem[{rd_ch, rd_ptr_q[rd_ch][PTR_SIZE-1:0]}] : data_q;
    err_d = (err_q & ~{NUM_CH{err_clr}}) | err_set;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr_q <= '{default: '0};
      rd_ptr_q <= '{default: '0};
      data_q <= '0;
      valid_q <= 1'b0;
      err_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data_q <= data_d;
      valid_q <= rd_ok;
      err_q <= err_d;
    end
  // Storage is not reset; reset empties channels by clearing the pointers.
  always_ff @(posedge clk)
    if (wr_ok) mem[{wr_ch, wr_ptr_q[wr_ch][PTR_SIZE-1:0]}] <= data_in;
  assign data_out = data_q;
  assign data_valid = valid_q;
  assign error_flag = err_q;
endmodule
